exec_mem_wb: RTL and testbench

EXEC_MEM_WB -- requirements
Module: exec_mem_wb

---
 rtl/exec_mem_wb.sv | 159 +++++++++++++++
 tb/tb_exec_mem_wb.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/exec_mem_wb.sv
// exec_mem_wb: multi-cycle execute / memory / write-back unit for a small
// RV32I subset (lw, sw, addi, sub, xor, srl, beq).
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   in_valid        - decoded instruction fields valid (accepted when in_ready)
//   in_ready        - unit idle and able to accept an instruction
//   opcode, rd, rs1, rs2, funct3, funct7, immediate - decoded fields
//   done            - one-cycle retire pulse
//   illegal         - unsupported instruction (valid with done)
//   branch_taken    - beq condition true (valid with done)
//   branch_offset   - sign-extended {immediate,1'b0} of the latched instruction
//   wb_data         - ALU result, load data or store address (valid with done)
//   dbg_addr/dbg_data - combinational register-file read port
module exec_mem_wb (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [11:0] immediate,
    output logic        done,
    output logic        illegal,
    output logic        branch_taken,
    output logic [31:0] branch_offset,
    output logic [31:0] wb_data,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREG  = 32;
    localparam int unsigned NWORD = 32;
    localparam int unsigned RW    = 5;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {IDLE, EX, MEM, WB} state_t;

    state_t            state;
    logic [6:0]        op_q;
    logic [RW-1:0]     rd_q;
    logic [RW-1:0]     rs1_q;
    logic [RW-1:0]     rs2_q;
    logic [2:0]        f3_q;
    logic [6:0]        f7_q;
    logic [11:0]       imm_q;
    logic [XLEN-1:0]   result_q;
    logic [XLEN-1:0]   rf  [NREG];
    logic [XLEN-1:0]   mem [NWORD];

    logic              is_lw, is_sw, is_addi, is_sub, is_xor, is_srl, is_beq;
    logic              is_mem, is_legal, writes_rd;
    logic [XLEN-1:0]   rs1_val, rs2_val, imm_sext, addr, alu;

    assign in_ready      = (state == IDLE);
    assign branch_offset = {{19{imm_q[11]}}, imm_q, 1'b0};
    assign dbg_data      = rf[dbg_addr];

    // Decode of the latched instruction and EX-stage datapath
    always_comb begin
        is_lw     = (op_q == OP_LOAD)   && (f3_q == 3'b010);
        is_sw     = (op_q == OP_STORE)  && (f3_q == 3'b010);
        is_addi   = (op_q == OP_IMM)    && (f3_q == 3'b000);
        is_sub    = (op_q == OP_REG)    && (f3_q == 3'b000) && (f7_q == 7'b0100000);
        is_xor    = (op_q == OP_REG)    && (f3_q == 3'b100) && (f7_q == 7'b0000000);
        is_srl    = (op_q == OP_REG)    && (f3_q == 3'b101) && (f7_q == 7'b0000000);
        is_beq    = (op_q == OP_BRANCH) && (f3_q == 3'b000);
        is_mem    = is_lw || is_sw;
        is_legal  = is_mem || is_addi || is_sub || is_xor || is_srl || is_beq;
        writes_rd = is_lw || is_addi || is_sub || is_xor || is_srl;

        rs1_val  = rf[rs1_q];
        rs2_val  = rf[rs2_q];
        imm_sext = {{20{imm_q[11]}}, imm_q};
        addr     = rs1_val + imm_sext;

        // Zero for anything without an ALU result (illegal, beq, lw/sw)
        alu = '0;
        if (is_addi)     alu = addr;
        else if (is_sub) alu = rs1_val - rs2_val;
        else if (is_xor) alu = rs1_val ^ rs2_val;
        else if (is_srl) alu = rs1_val >> rs2_val[4:0];
    end

    // Control FSM, register file and data memory
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            done         <= 1'b0;
            illegal      <= 1'b0;
            branch_taken <= 1'b0;
            wb_data      <= '0;
            result_q     <= '0;
            op_q         <= '0;
            rd_q         <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            f3_q         <= '0;
            f7_q         <= '0;
            imm_q        <= '0;
            for (int unsigned i = 0; i < NREG; i++)  rf[RW'(i)]  <= '0;
            for (int unsigned i = 0; i < NWORD; i++) mem[RW'(i)] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_q  <= opcode;
                        rd_q  <= rd;
                        rs1_q <= rs1;
                        rs2_q <= rs2;
                        f3_q  <= funct3;
                        f7_q  <= funct7;
                        imm_q <= immediate;
                        state <= EX;
                    end
                end
                EX: begin
                    result_q     <= is_mem ? addr : alu;
                    wb_data      <= alu;
                    illegal      <= !is_legal;
                    branch_taken <= is_beq && (rs1_val == rs2_val);
                    if (is_mem) begin
                        state <= MEM;
                    end else begin
                        state <= WB;
                        done  <= 1'b1;
                    end
                end
                MEM: begin
                    // Word index only; low and high address bits wrap silently
                    if (is_sw) begin
                        mem[result_q[6:2]] <= rs2_val;
                        wb_data            <= result_q;
                    end else begin
                        wb_data <= mem[result_q[6:2]];
                    end
                    done  <= 1'b1;
                    state <= WB;
                end
                WB: begin
                    if (writes_rd && (rd_q != '0)) rf[rd_q] <= wb_data;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exec_mem_wb.sv
// Directed self-checking bench for exec_mem_wb.
module tb_exec_mem_wb;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [11:0] immediate;
    logic        done, illegal, branch_taken;
    logic [31:0] branch_offset, wb_data, dbg_data;
    logic [4:0]  dbg_addr;

    int pass_cnt  = 0;
    int total_cnt = 0;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    exec_mem_wb dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .opcode        (opcode),
        .rd            (rd),
        .rs1           (rs1),
        .rs2           (rs2),
        .funct3        (funct3),
        .funct7        (funct7),
        .immediate     (immediate),
        .done          (done),
        .illegal       (illegal),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .wb_data       (wb_data),
        .dbg_addr      (dbg_addr),
        .dbg_data      (dbg_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Read a register through the debug port; consumes one idle cycle
    task automatic dbg(input string tag, input logic [4:0] a, input logic [31:0] exp);
        dbg_addr = a;
        #1;
        check(tag, dbg_data, exp);
        step();
    endtask

    // Issue one instruction from IDLE (#1 after an edge) and check the retire
    task automatic run(input string tag, input logic [6:0] op, input logic [4:0] d,
                       input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [11:0] imm, input int lat,
                       input bit chk_wb, input logic [31:0] exp_wb,
                       input logic exp_ill, input logic exp_bt, input bit hold);
        in_valid  = 1'b1;
        opcode    = op;
        rd        = d;
        rs1       = s1;
        rs2       = s2;
        funct3    = f3;
        funct7    = f7;
        immediate = imm;
        check({tag, ".ready"}, 32'(in_ready), 32'd1);
        step();
        if (hold) begin
            // Junk fields presented while busy must not be taken
            rd        = 5'd10;
            immediate = 12'd99;
        end else begin
            in_valid = 1'b0;
        end
        check({tag, ".busy"}, 32'(in_ready), 32'd0);
        for (int i = 1; i < lat; i++) begin
            check({tag, ".early_done"}, 32'(done), 32'd0);
            step();
        end
        in_valid = 1'b0;
        check({tag, ".done"}, 32'(done), 32'd1);
        if (chk_wb) check({tag, ".wb_data"}, wb_data, exp_wb);
        check({tag, ".illegal"}, 32'(illegal), 32'(exp_ill));
        check({tag, ".branch"}, 32'(branch_taken), 32'(exp_bt));
        step();
        check({tag, ".done_pulse"}, 32'(done), 32'd0);
        check({tag, ".ready_after"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        opcode    = '0;
        rd        = '0;
        rs1       = '0;
        rs2       = '0;
        funct3    = '0;
        funct7    = '0;
        immediate = '0;
        dbg_addr  = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        check("rst.ready",   32'(in_ready),     32'd1);
        check("rst.done",    32'(done),         32'd0);
        check("rst.illegal", 32'(illegal),      32'd0);
        check("rst.branch",  32'(branch_taken), 32'd0);
        check("rst.wb_data", wb_data,           32'd0);
        check("rst.offset",  branch_offset,     32'd0);

        // ALU ops with back-to-back read-after-write
        run("addi1", OP_IMM, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 12'd5, 2, 1, 32'd5, 0, 0, 0);
        run("addi2", OP_IMM, 5'd2, 5'd0, 5'd0, 3'b000, 7'd0, 12'd3, 2, 1, 32'd3, 0, 0, 0);
        dbg("x1", 5'd1, 32'd5);
        dbg("x2", 5'd2, 32'd3);
        run("sub", OP_REG, 5'd3, 5'd2, 5'd1, 3'b000, 7'b0100000, 12'd0, 2, 1, 32'hFFFF_FFFE, 0, 0, 0);
        run("xor", OP_REG, 5'd4, 5'd1, 5'd2, 3'b100, 7'b0000000, 12'd0, 2, 1, 32'd6, 0, 0, 0);
        run("srl", OP_REG, 5'd5, 5'd3, 5'd1, 3'b101, 7'b0000000, 12'd0, 2, 1, 32'h07FF_FFFF, 0, 0, 0);
        dbg("x3", 5'd3, 32'hFFFF_FFFE);
        dbg("x4", 5'd4, 32'd6);
        dbg("x5", 5'd5, 32'h07FF_FFFF);
        run("addi_neg", OP_IMM, 5'd8, 5'd1, 5'd0, 3'b000, 7'd0, 12'hFFF, 2, 1, 32'd4, 0, 0, 0);

        // Memory: store address on wb_data, load back, wrapped address
        run("sw8", OP_STORE, 5'd0, 5'd0, 5'd1, 3'b010, 7'd0, 12'd8, 3, 1, 32'd8, 0, 0, 0);
        run("lw8", OP_LOAD, 5'd6, 5'd0, 5'd0, 3'b010, 7'd0, 12'd8, 3, 1, 32'd5, 0, 0, 0);
        dbg("x6", 5'd6, 32'd5);
        run("lw_wrap", OP_LOAD, 5'd7, 5'd0, 5'd0, 3'b010, 7'd0, 12'h08B, 3, 1, 32'd5, 0, 0, 0);
        dbg("x7", 5'd7, 32'd5);

        // Branches
        run("beq_t", OP_BRANCH, 5'd0, 5'd1, 5'd1, 3'b000, 7'd0, 12'hFFE, 2, 0, 32'd0, 0, 1, 0);
        check("beq_t.offset", branch_offset, 32'hFFFF_FFFC);
        run("beq_nt", OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 12'h004, 2, 0, 32'd0, 0, 0, 0);
        check("beq_nt.offset", branch_offset, 32'h0000_0008);
        dbg("x1_after_beq", 5'd1, 32'd5);
        dbg("x2_after_beq", 5'd2, 32'd3);

        // x0 is hard-wired, illegal ops retire without side effects
        run("addi_x0", OP_IMM, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 12'd7, 2, 1, 32'd7, 0, 0, 0);
        dbg("x0", 5'd0, 32'd0);
        run("lui_ill", OP_LUI, 5'd4, 5'd1, 5'd2, 3'b000, 7'd0, 12'd1, 2, 1, 32'd0, 1, 0, 1);
        run("add_ill", OP_REG, 5'd4, 5'd1, 5'd2, 3'b000, 7'b0000000, 12'd0, 2, 1, 32'd0, 1, 0, 0);
        dbg("x4_after_ill", 5'd4, 32'd6);
        run("addi_hold", OP_IMM, 5'd9, 5'd0, 5'd0, 3'b000, 7'd0, 12'd9, 2, 1, 32'd9, 0, 0, 1);
        dbg("x9", 5'd9, 32'd9);
        dbg("x10", 5'd10, 32'd0);

        // Reset in MEM of a store: discarded, no retire, state cleared
        in_valid  = 1'b1;
        opcode    = OP_STORE;
        rd        = 5'd0;
        rs1       = 5'd0;
        rs2       = 5'd1;
        funct3    = 3'b010;
        funct7    = 7'd0;
        immediate = 12'd12;
        step();
        in_valid = 1'b0;
        step();
        check("mrst.in_mem", 32'(done), 32'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mrst.done",  32'(done),     32'd0);
        check("mrst.ready", 32'(in_ready), 32'd1);
        dbg("mrst.x1", 5'd1, 32'd0);
        check("mrst.done_later", 32'(done), 32'd0);
        run("mrst.lw12", OP_LOAD, 5'd6, 5'd0, 5'd0, 3'b010, 7'd0, 12'd12, 3, 1, 32'd0, 0, 0, 0);
        run("mrst.lw8", OP_LOAD, 5'd6, 5'd0, 5'd0, 3'b010, 7'd0, 12'd8, 3, 1, 32'd0, 0, 0, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
